// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// fetch-state encoding and the {pc, inst} buffer entry.
package fetch_unit_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 2;

    typedef enum logic [1:0] {
        FS_RUN   = 2'd0,
        FS_FLUSH = 2'd1,
        FS_ERROR = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small register-based FIFO with occupancy count and synchronous clear.
// The head entry is read straight from register storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign do_push = push & ~clear & ((count_q != CW'(DEPTH)) | pop);
    assign do_pop  = pop & ~clear & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign mem_d[gi] = (do_push && (wr_ptr_q == PW'(gi))) ? push_data : mem_q[gi];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues PC requests under a credit limit,
// tags returned instructions with their PC and discards stale responses after a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    input  logic              redirect,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              fetch_err
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    localparam logic [1:0] ST_RUN   = FS_RUN;
    localparam logic [1:0] ST_FLUSH = FS_FLUSH;
    localparam logic [1:0] ST_ERROR = FS_ERROR;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     pend;
    logic [CW-1:0]     buf_count;
    logic [ADDR_W-1:0] head_pc;
    entry_t            rsp_entry;
    entry_t            head_entry;
    logic              aligned;
    logic              credit;
    logic              inst_pop;
    logic              req_fire;
    logic              rsp_live;
    logic [CW:0]       occupancy;
    logic [CW:0]       in_flight;

    assign aligned    = (pc[1:0] == 2'b00);
    assign inst_valid = (buf_count != '0);
    assign inst_pop   = inst_valid & inst_ready;

    // The slot vacated by decode this cycle is counted as free, so latency-1
    // memory sustains one instruction per cycle with only two slots.
    assign occupancy = {1'b0, pend} + {1'b0, buf_count} - {{CW{1'b0}}, inst_pop};
    assign credit    = (occupancy < DEPTH_C);

    assign imem_req_valid = reset_n & (state_q == ST_RUN) & credit & ~redirect & aligned;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pc_en          = req_fire;
    assign fetch_err      = (state_q == ST_ERROR);

    // Responses are kept unless they belong to requests abandoned by a redirect.
    assign rsp_live  = imem_rsp_valid & ~redirect & (state_q != ST_FLUSH);
    assign in_flight = {1'b0, pend} + {1'b0, drop_q};

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        if (redirect) begin
            drop_d  = CW'(in_flight - {{CW{1'b0}}, imem_rsp_valid});
            state_d = (drop_d != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (credit && !aligned) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_FLUSH: begin
                    if (imem_rsp_valid && (drop_q != '0)) begin
                        drop_d = drop_q - 1'b1;
                    end
                    if ((drop_q == '0) || (imem_rsp_valid && (drop_q == CW'(1)))) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (redirect),
        .push      (req_fire),
        .push_data (pc),
        .pop       (rsp_live),
        .pop_data  (head_pc),
        .count     (pend)
    );

    assign rsp_entry = '{pc: head_pc, inst: imem_rsp_data};

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (redirect),
        .push      (rsp_live),
        .push_data (rsp_entry),
        .pop       (inst_pop),
        .pop_data  (head_entry),
        .count     (buf_count)
    );

    assign inst    = head_entry.inst;
    assign inst_pc = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model feeds
// responses, and accepted requests queue the {pc, inst} expected at decode.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b1;
    logic [31:0] pc_r       = '0;
    logic        redirect   = 1'b0;
    logic        req_ready  = 1'b0;
    logic        rsp_valid  = 1'b0;
    logic [31:0] rsp_data   = '0;
    logic        inst_ready = 1'b0;

    logic        pc_en;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pc             (pc_r),
        .pc_en          (pc_en),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (req_ready),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_err      (fetch_err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        mq[$];
    fetch_entry_t exp_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] redir_tgt = '0;
    int          n_accept = 0;
    int          n_deliv = 0;
    int          first_accept = -1;
    int          first_inst = -1;
    int          last_accept = -1;
    int          last_rsp = -1;
    logic        last_pc_en = 1'b0;
    int          base_a;
    int          base_d;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // One clock: sample at the falling edge, then drive next-cycle inputs after the rising edge.
    task automatic cycle();
        logic [31:0]  pc_next;
        fetch_entry_t e;
        @(negedge clock);
        pc_next = pc_r;
        check("pc_en", {63'd0, pc_en}, {63'd0, imem_req_valid & req_ready});
        if (redirect) check("redirect_no_req", {63'd0, imem_req_valid}, 64'd0);
        if (inst_valid && inst_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check("unexpected_inst", {63'd0, inst_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", {32'd0, inst_pc}, {32'd0, e.pc});
                check("inst", {32'd0, inst}, {32'd0, e.inst});
                n_deliv++;
                if (first_inst < 0) first_inst = cyc;
            end
        end
        if (imem_req_valid) check("req_addr", {32'd0, imem_req_addr}, {32'd0, pc_r});
        if (imem_req_valid && req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            exp_q.push_back('{pc: pc_r, inst: mem_word(pc_r)});
            n_accept++;
            last_accept = cyc;
            if (first_accept < 0) first_accept = cyc;
            pc_next = pc_r + 32'd4;
        end
        last_pc_en = pc_en;
        if (rsp_valid) last_rsp = cyc;
        if (redirect) begin
            exp_q.delete();
            pc_next = redir_tgt;
        end
        @(posedge clock);
        cyc++;
        #1;
        pc_r     = pc_next;
        redirect = 1'b0;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    endtask

    task automatic drain();
        req_ready  = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (mq.size() == 0 && exp_q.size() == 0 && !rsp_valid && !inst_valid) break;
            cycle();
        end
        check("drain_pending", exp_q.size(), 0);
        cycle();
        cycle();
    endtask

    task automatic wait_new_req(input string tag);
        int start;
        start = n_accept;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (n_accept != start) break;
        end
        req_ready = 1'b0;
        check({tag, "_accepts"}, n_accept - start, 1);
        check({tag, "_after_stale"}, last_accept, last_rsp + 1);
        check({tag, "_stale_delivered"}, n_deliv - base_d, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
        check({tag, "_pc_en"}, {63'd0, pc_en}, 64'd0);
        check({tag, "_inst_valid"}, {63'd0, inst_valid}, 64'd0);
        check({tag, "_inst"}, {32'd0, inst}, 64'd0);
        check({tag, "_inst_pc"}, {32'd0, inst_pc}, 64'd0);
        check({tag, "_fetch_err"}, {63'd0, fetch_err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n    = 1'b1;
        pc_r       = 32'h0;
        lat        = 1;
        req_ready  = 1'b1;
        inst_ready = 1'b1;

        // Streaming, 1-cycle memory.
        repeat (20) cycle();
        check("first_inst_latency", first_inst - first_accept, 2);
        check("stream_accepts", n_accept, 20);
        check("stream_delivered", n_deliv, 18);
        drain();

        // Backpressure from an idle pipeline.
        base_a     = n_accept;
        inst_ready = 1'b0;
        req_ready  = 1'b1;
        repeat (5) cycle();
        check("bp_accepts", n_accept - base_a, 2);
        check("bp_pc_en_held", {63'd0, last_pc_en}, 64'd0);
        check("bp_inst_valid", {63'd0, inst_valid}, 64'd1);
        base_d = n_deliv;
        drain();
        check("bp_delivered", n_deliv - base_d, 2);

        // Redirect with two requests in flight, 3-cycle memory.
        lat        = 3;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        base_d     = n_deliv;
        cycle();
        cycle();
        redirect  = 1'b1;
        redir_tgt = 32'h0000_0100;
        cycle();
        wait_new_req("redir_inflight");
        drain();

        // Redirect in the same cycle as the first stale response.
        req_ready = 1'b1;
        base_d    = n_deliv;
        cycle();
        cycle();
        cycle();
        check("coinc_rsp_present", {63'd0, rsp_valid}, 64'd1);
        redirect  = 1'b1;
        redir_tgt = 32'h0000_0200;
        cycle();
        wait_new_req("redir_coincident");
        drain();

        // Misaligned PC, then recovery by redirect.
        lat        = 1;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        pc_r       = 32'h0000_0006;
        base_a     = n_accept;
        repeat (3) begin
            cycle();
            #1;
            check("err_sticky", {63'd0, fetch_err}, 64'd1);
            check("err_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        check("err_no_accept", n_accept - base_a, 0);
        redirect  = 1'b1;
        redir_tgt = 32'h0000_0008;
        cycle();
        #1;
        check("err_cleared", {63'd0, fetch_err}, 64'd0);
        check("err_recover_req", {63'd0, imem_req_valid}, 64'd1);
        check("err_recover_addr", {32'd0, imem_req_addr}, 64'h8);
        cycle();
        check("err_recover_accept", n_accept - base_a, 1);
        drain();

        // Asynchronous reset in the middle of a stream.
        pc_r       = 32'h0000_0040;
        req_ready  = 1'b1;
        inst_ready = 1'b1;
        repeat (5) cycle();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        mq.delete();
        exp_q.delete();
        rsp_valid = 1'b0;
        rsp_data  = '0;
        @(posedge clock);
        @(posedge clock);
        #1;
        pc_r    = 32'h0040_0000;
        reset_n = 1'b1;
        #2;
        check("post_reset_req_valid", {63'd0, imem_req_valid}, 64'd1);
        check("post_reset_req_addr", {32'd0, imem_req_addr}, 64'h0040_0000);
        cycle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
